// File: rtl/mixcol_seq.sv
// -----------------------------------------------------------------------------
// mixcol_seq
//
// Applies AES MixColumns to a full 128-bit state, one 32-bit column per clock,
// through a single shared column datapath (mixcolum). Sits between ShiftRows and
// AddRoundKey. A bypass flag, captured with the state, lets the final round pass
// the state through unmixed.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    upstream presents a state on in_state
//   in_ready   out  1    block accepts a state this cycle (IDLE only)
//   in_state   in   128  column-major state; column 0 = [127:96], row 0 = [31:24]
//   in_bypass  in   1    1 = final round, state passes through unmixed
//   out_valid  out  1    out_state holds a completed result (DONE only)
//   out_ready  in   1    downstream takes the result this cycle
//   out_state  out  128  result, same layout as in_state
//   busy       out  1    high while mixing or holding a result
// -----------------------------------------------------------------------------

// Single MixColumns column: fixed matrix 2 3 1 1 / 1 2 3 1 / 1 1 2 3 / 3 1 1 2
// over GF(2^8) with reduction polynomial 0x11B. Row 0 is col_i[31:24].
module mixcolum (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    // Multiply by x (i.e. by 2) in GF(2^8), reducing by 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // 3*a is computed as xtime(a) ^ a.
    assign col_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

module mixcol_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] buf_q, buf_d;
    logic [31:0]  mix_in, mix_out;

    // Column selected by the counter feeds the one shared column datapath.
    always_comb begin
        case (col_q)
            2'd0:    mix_in = buf_q[127:96];
            2'd1:    mix_in = buf_q[95:64];
            2'd2:    mix_in = buf_q[63:32];
            default: mix_in = buf_q[31:0];
        endcase
    end

    mixcolum u_mixcolum (
        .col_i (mix_in),
        .col_o (mix_out)
    );

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        buf_d   = buf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d   = in_state;
                    col_d   = 2'd0;
                    state_d = in_bypass ? ST_DONE : ST_MIX;
                end
            end

            ST_MIX: begin
                case (col_q)
                    2'd0:    buf_d[127:96] = mix_out;
                    2'd1:    buf_d[95:64]  = mix_out;
                    2'd2:    buf_d[63:32]  = mix_out;
                    default: buf_d[31:0]   = mix_out;
                endcase
                col_d = col_q + 2'd1;       // wraps 3 -> 0
                if (col_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Buffer held untouched so out_state is stable while valid.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the data buffer is reset too, so out_state reads zero after reset
    // and a partially mixed state never leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
        end
    end

    // All outputs decode from registers only: no combinational path from
    // in_valid or out_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_state = buf_q;

endmodule

// File: tb/tb_mixcol_seq.sv
// -----------------------------------------------------------------------------
// tb_mixcol_seq
//
// Self-checking bench for mixcol_seq: known-answer table, back-pressure,
// asynchronous reset during mixing, and a randomized back-to-back stream
// checked against a GF(2^8) matrix-multiply reference model.
// -----------------------------------------------------------------------------
module tb_mixcol_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    mixcol_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    // Carry-less polynomial product followed by reduction modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (15'h11b << (k - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s);
        int unsigned m [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) a[row] = s[127 - 32*c - 8*row -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(8'(m[row][k]), a[k]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the accept edge.
    task automatic send(input logic [127:0] s, input logic byp);
        int guard;
        guard     = 0;
        in_state  = s;
        in_bypass = byp;
        in_valid  = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("send_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accept until out_valid is seen; returns the data.
    task automatic wait_out(output int lat, output logic [127:0] data);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("valid_seen", 128'(out_valid), 128'd1);
        data = out_state;
    endtask

    typedef struct {
        string        name;
        logic [127:0] stim;
        logic         bypass;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t         vecs [3];
    int           lat;
    logic [127:0] got;
    logic [127:0] st_a, st_b;
    logic         saw_valid;

    logic [127:0] bb_s [8];
    logic         bb_b [8];
    int           acc_cyc [8];
    logic [127:0] exp_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, nout, cyc;
        logic was_ready;

        vecs[0] = '{"fips_mix",  128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                                 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4};
        vecs[1] = '{"set2_mix",  128'hd4d4d4d5_2d26314c_db135345_f20a225c, 1'b0,
                                 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d, 4};
        // Bypass goes straight to DONE: result is visible right after accept.
        vecs[2] = '{"bypass",    128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1,
                                 128'hdb135345_f20a225c_01010101_c6c6c6c6, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_bypass = 1'b0;
        out_ready = 1'b1;

        // ---------------------------------------------------- reset state
        #3;
        check("rst_in_ready",  128'(in_ready),  128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_out_state", out_state,       128'd0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // --------------------------------------------------- vector table
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            send(vecs[i].stim, vecs[i].bypass);
            check({vecs[i].name, "_busy"}, 128'(busy), 128'd1);
            wait_out(lat, got);
            check({vecs[i].name, "_data"}, got, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 128'(lat), 128'(vecs[i].lat));
            @(posedge clk); #1;
            check({vecs[i].name, "_idle"}, 128'(in_ready), 128'd1);
        end

        // --------------------------------------------------- back-pressure
        st_a = {$urandom, $urandom, $urandom, $urandom};
        st_b = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        send(st_a, 1'b0);
        wait_out(lat, got);
        check("bp_first_data", got, mix_state(st_a));
        in_state  = st_b;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold_state", out_state, mix_state(st_a));
            check("bp_hold_ready", 128'(in_ready), 128'd0);
            check("bp_hold_valid", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;     // handoff edge: no accept here
        check("bp_handoff_ready", 128'(in_ready), 128'd1);
        check("bp_handoff_valid", 128'(out_valid), 128'd0);
        @(posedge clk); #1;     // second state accepted here
        in_valid = 1'b0;
        check("bp_second_busy", 128'(busy), 128'd1);
        wait_out(lat, got);
        check("bp_second_data", got, mix_state(st_b));
        check("bp_second_lat", 128'(lat), 128'd4);
        @(posedge clk); #1;

        // ------------------------------------------------- reset mid-MIX
        send(vecs[0].stim, 1'b0);
        @(posedge clk);         // column 0 written
        @(posedge clk);         // column 1 written
        #2 rst = 1'b1;
        #1;
        check("mrst_in_ready",  128'(in_ready),  128'd1);
        check("mrst_out_valid", 128'(out_valid), 128'd0);
        check("mrst_busy",      128'(busy),      128'd0);
        check("mrst_out_state", out_state,       128'd0);
        saw_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            saw_valid = saw_valid | out_valid;
        end
        #2 rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            saw_valid = saw_valid | out_valid;
        end
        check("mrst_no_valid", 128'(saw_valid), 128'd0);
        send(vecs[1].stim, 1'b0);
        wait_out(lat, got);
        check("mrst_next_data", got, vecs[1].exp);
        @(posedge clk); #1;

        // ------------------------------------------------- back-to-back
        for (int i = 0; i < 8; i++) begin
            bb_s[i] = {$urandom, $urandom, $urandom, $urandom};
            bb_b[i] = 1'($urandom_range(0, 1));
        end
        bb_b[0] = 1'b0;
        bb_b[1] = 1'b1;
        idx  = 0;
        nout = 0;
        cyc  = 0;
        out_ready = 1'b1;
        in_state  = bb_s[0];
        in_bypass = bb_b[0];
        in_valid  = 1'b1;
        while ((idx < 8 || nout < 8) && cyc < 400) begin
            was_ready = in_ready;
            @(posedge clk);
            cyc++;
            if (was_ready && in_valid) begin
                acc_cyc[idx] = cyc;
                exp_q.push_back(bb_b[idx] ? bb_s[idx] : mix_state(bb_s[idx]));
                idx++;
            end
            #1;
            if (idx < 8) begin
                in_state  = bb_s[idx];
                in_bypass = bb_b[idx];
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check("b2b_data", out_state, exp_q.pop_front());
                end else begin
                    check("b2b_extra_valid", 128'(out_valid), 128'd0);
                end
                nout++;
            end
        end
        check("b2b_accepts", 128'(idx), 128'd8);
        check("b2b_results", 128'(nout), 128'd8);
        for (int i = 0; i < 7; i++) begin
            check("b2b_spacing", 128'(acc_cyc[i+1] - acc_cyc[i]), bb_b[i] ? 128'd2 : 128'd6);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
